mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mc_ctrl                                                    |
// | Description : Multi-cycle RV32I control unit. Sequences FETCH, DECODE,   |
// |               EXECUTE, MEM and WB, registers the ALU operation select,   |
// |               and traps on illegal encodings or memory timeouts.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mc_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic [4:0]  alu_control,
  output logic        op2_sel,
  output logic        ir_we,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        reg_we,
  output logic        wb_sel,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        retire,
  output logic        halted,
  output logic        illegal,
  output logic        bus_err
);

  localparam logic [2:0] c_st_fetch   = 3'd0;
  localparam logic [2:0] c_st_decode  = 3'd1;
  localparam logic [2:0] c_st_execute = 3'd2;
  localparam logic [2:0] c_st_mem     = 3'd3;
  localparam logic [2:0] c_st_wb      = 3'd4;
  localparam logic [2:0] c_st_trap    = 3'd5;

  localparam logic [6:0] c_op_r      = 7'b0110011;
  localparam logic [6:0] c_op_imm    = 7'b0010011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_branch = 7'b1100011;

  localparam logic [6:0] c_f7_zero = 7'b0000000;
  localparam logic [6:0] c_f7_alt  = 7'b0100000;

  // Last wait-counter value before a stalled access is declared dead
  localparam logic [7:0] c_wait_last = 8'(TIMEOUT_CYCLES - 1);

  logic [2:0] r_state;
  logic [2:0] w_state_nxt;
  logic [7:0] r_wait;
  logic [7:0] w_wait_nxt;
  logic [6:0] r_opcode;
  logic [2:0] r_funct3;
  // Full funct7 is kept (not just bit 5) so DECODE can reject stray bits
  logic [6:0] r_funct7;
  logic       r_halted;
  logic       r_illegal;
  logic       r_bus_err;

  logic       w_dec_ok;
  logic [4:0] w_dec_alu;
  logic       w_dec_op2;
  logic       w_set_ill;
  logic       w_set_bus;
  logic       w_load_dec;
  logic       w_is_load;
  logic       w_is_store;
  logic       w_is_branch;

  // Register operands, rd and immediate bits are consumed by the datapath
  logic       w_unused_instr_bits;
  assign w_unused_instr_bits = ^{instr[24:15], instr[11:7]};

  assign w_is_load   = (r_opcode == c_op_load);
  assign w_is_store  = (r_opcode == c_op_store);
  assign w_is_branch = (r_opcode == c_op_branch);

  // Shared R/I funct3 mapping; alt selects SUB/SRA
  function automatic logic [4:0] alu_map(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_map = alt ? 5'd1 : 5'd0;
      3'b001:  alu_map = 5'd5;
      3'b010:  alu_map = 5'd8;
      3'b011:  alu_map = 5'd9;
      3'b100:  alu_map = 5'd2;
      3'b101:  alu_map = alt ? 5'd7 : 5'd6;
      3'b110:  alu_map = 5'd3;
      default: alu_map = 5'd4;
    endcase
  endfunction

  // Decode the captured instruction fields into ALU select and legality
  always_comb begin
    w_dec_ok  = 1'b1;
    w_dec_alu = 5'd0;
    w_dec_op2 = 1'b0;
    case (r_opcode)
      c_op_r: begin
        if (r_funct7 == c_f7_zero)
          w_dec_alu = alu_map(r_funct3, 1'b0);
        else if (r_funct7 == c_f7_alt && (r_funct3 == 3'b000 || r_funct3 == 3'b101))
          w_dec_alu = alu_map(r_funct3, 1'b1);
        else
          w_dec_ok = 1'b0;
      end
      c_op_imm: begin
        w_dec_op2 = 1'b1;
        w_dec_alu = alu_map(r_funct3, 1'b0);
        if (r_funct3 == 3'b001 && r_funct7 != c_f7_zero)
          w_dec_ok = 1'b0;
        if (r_funct3 == 3'b101) begin
          if (r_funct7 == c_f7_alt)
            w_dec_alu = 5'd7;
          else if (r_funct7 != c_f7_zero)
            w_dec_ok = 1'b0;
        end
      end
      c_op_load, c_op_store: w_dec_op2 = 1'b1;
      c_op_lui:   w_dec_alu = 5'd16;
      c_op_auipc: w_dec_alu = 5'd17;
      c_op_jal:   w_dec_alu = 5'd18;
      c_op_jalr: begin
        w_dec_alu = 5'd19;
        w_dec_ok  = (r_funct3 == 3'b000);
      end
      c_op_branch: begin
        case (r_funct3)
          3'b000:  w_dec_alu = 5'd10;
          3'b001:  w_dec_alu = 5'd11;
          3'b100:  w_dec_alu = 5'd12;
          3'b101:  w_dec_alu = 5'd13;
          3'b110:  w_dec_alu = 5'd14;
          3'b111:  w_dec_alu = 5'd15;
          default: w_dec_ok  = 1'b0;
        endcase
      end
      default: w_dec_ok = 1'b0;
    endcase
  end

  // Next-state and wait-counter logic; a ready strobe beats the timeout
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = 8'd0;
    w_set_ill   = 1'b0;
    w_set_bus   = 1'b0;
    w_load_dec  = 1'b0;
    case (r_state)
      c_st_fetch, c_st_mem: begin
        if (mem_ready) begin
          if (r_state == c_st_fetch)
            w_state_nxt = c_st_decode;
          else
            w_state_nxt = w_is_load ? c_st_wb : c_st_fetch;
        end else if (r_wait == c_wait_last) begin
          w_state_nxt = c_st_trap;
          w_set_bus   = 1'b1;
        end else begin
          w_wait_nxt = r_wait + 8'd1;
        end
      end
      c_st_decode: begin
        if (w_dec_ok) begin
          w_state_nxt = c_st_execute;
          w_load_dec  = 1'b1;
        end else begin
          w_state_nxt = c_st_trap;
          w_set_ill   = 1'b1;
        end
      end
      c_st_execute: begin
        if (w_is_branch)
          w_state_nxt = c_st_fetch;
        else if (w_is_load || w_is_store)
          w_state_nxt = c_st_mem;
        else
          w_state_nxt = c_st_wb;
      end
      c_st_wb:   w_state_nxt = c_st_fetch;
      c_st_trap: w_state_nxt = c_st_trap;
      default:   w_state_nxt = c_st_fetch;
    endcase
  end

  // State, captured instruction fields, ALU select and sticky trap flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= c_st_fetch;
      r_wait      <= 8'd0;
      alu_control <= 5'd0;
      op2_sel     <= 1'b0;
      r_halted    <= 1'b0;
      r_illegal   <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
      if (w_load_dec) begin
        alu_control <= w_dec_alu;
        op2_sel     <= w_dec_op2;
      end
      if (w_state_nxt == c_st_trap)
        r_halted <= 1'b1;
      if (w_set_ill)
        r_illegal <= 1'b1;
      if (w_set_bus)
        r_bus_err <= 1'b1;
    end
  end

  // Opcode fields are latched with the instruction register write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_opcode <= 7'd0;
      r_funct3 <= 3'd0;
      r_funct7 <= 7'd0;
    end else if (r_state == c_st_fetch && mem_ready) begin
      r_opcode <= instr[6:0];
      r_funct3 <= instr[14:12];
      r_funct7 <= instr[31:25];
    end
  end

  // State-decoded control strobes, forced low while reset is held
  always_comb begin
    ir_we    = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    reg_we   = 1'b0;
    wb_sel   = 1'b0;
    pc_we    = 1'b0;
    pc_src   = 2'd0;
    retire   = 1'b0;
    if (rst_n) begin
      case (r_state)
        c_st_fetch: begin
          mem_req = 1'b1;
          ir_we   = mem_ready;
        end
        c_st_execute: begin
          if (w_is_branch) begin
            pc_we  = 1'b1;
            pc_src = branch_taken ? 2'd1 : 2'd0;
            retire = 1'b1;
          end
        end
        c_st_mem: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = w_is_store;
          if (mem_ready && w_is_store) begin
            pc_we  = 1'b1;
            retire = 1'b1;
          end
        end
        c_st_wb: begin
          reg_we = 1'b1;
          wb_sel = w_is_load;
          pc_we  = 1'b1;
          retire = 1'b1;
          if (r_opcode == c_op_jal)
            pc_src = 2'd1;
          else if (r_opcode == c_op_jalr)
            pc_src = 2'd2;
        end
        default: ;
      endcase
    end
  end

  assign halted  = r_halted;
  assign illegal = r_illegal;
  assign bus_err = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mc_ctrl                                                 |
// | Description : Directed self-checking bench for mc_ctrl.                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mc_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        mem_ready;
  logic        branch_taken;
  logic [4:0]  alu_control;
  logic        op2_sel;
  logic        ir_we;
  logic        mem_req;
  logic        mem_we;
  logic        addr_sel;
  logic        reg_we;
  logic        wb_sel;
  logic        pc_we;
  logic [1:0]  pc_src;
  logic        retire;
  logic        halted;
  logic        illegal;
  logic        bus_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Bundle: {mem_req, mem_we, addr_sel, ir_we, reg_we, wb_sel, pc_we, pc_src, retire, halted, illegal, bus_err}
  logic [12:0] w_obs;
  assign w_obs = {mem_req, mem_we, addr_sel, ir_we, reg_we, wb_sel, pc_we, pc_src,
                  retire, halted, illegal, bus_err};

  localparam logic [12:0] E_NONE       = 13'b0_0_0_0_0_0_0_00_0_0_0_0;
  localparam logic [12:0] E_FETCH_RDY  = 13'b1_0_0_1_0_0_0_00_0_0_0_0;
  localparam logic [12:0] E_FETCH_WAIT = 13'b1_0_0_0_0_0_0_00_0_0_0_0;
  localparam logic [12:0] E_WB_ALU     = 13'b0_0_0_0_1_0_1_00_1_0_0_0;
  localparam logic [12:0] E_WB_JAL     = 13'b0_0_0_0_1_0_1_01_1_0_0_0;
  localparam logic [12:0] E_WB_JALR    = 13'b0_0_0_0_1_0_1_10_1_0_0_0;
  localparam logic [12:0] E_BR_T       = 13'b0_0_0_0_0_0_1_01_1_0_0_0;
  localparam logic [12:0] E_BR_N       = 13'b0_0_0_0_0_0_1_00_1_0_0_0;
  localparam logic [12:0] E_MEM_LD     = 13'b1_0_1_0_0_0_0_00_0_0_0_0;
  localparam logic [12:0] E_WB_LD      = 13'b0_0_0_0_1_1_1_00_1_0_0_0;
  localparam logic [12:0] E_MEM_ST     = 13'b1_1_1_0_0_0_0_00_0_0_0_0;
  localparam logic [12:0] E_TRAP_ILL   = 13'b0_0_0_0_0_0_0_00_0_1_1_0;
  localparam logic [12:0] E_TRAP_BUS   = 13'b0_0_0_0_0_0_0_00_0_1_0_1;

  mc_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr        (instr),
    .mem_ready    (mem_ready),
    .branch_taken (branch_taken),
    .alu_control  (alu_control),
    .op2_sel      (op2_sel),
    .ir_we        (ir_we),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .addr_sel     (addr_sel),
    .reg_we       (reg_we),
    .wb_sel       (wb_sel),
    .pc_we        (pc_we),
    .pc_src       (pc_src),
    .retire       (retire),
    .halted       (halted),
    .illegal      (illegal),
    .bus_err      (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Check the strobe bundle mid-cycle, then move to just after the next edge
  task automatic step(input string tag, input logic [12:0] exp);
    @(negedge clk);
    chk(tag, {19'd0, w_obs}, {19'd0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Four-cycle register/jump instruction with single-cycle fetch
  task automatic run_wb(input string tag, input logic [31:0] iw, input logic [4:0] exp_alu,
                        input logic chk_op2, input logic exp_op2, input logic [12:0] exp_wb);
    instr     = iw;
    mem_ready = 1'b1;
    step({tag, "_fetch"}, E_FETCH_RDY);
    step({tag, "_decode"}, E_NONE);
    chk({tag, "_alu"}, {27'd0, alu_control}, {27'd0, exp_alu});
    if (chk_op2)
      chk({tag, "_op2"}, {31'd0, op2_sel}, {31'd0, exp_op2});
    step({tag, "_execute"}, E_NONE);
    step({tag, "_wb"}, exp_wb);
  endtask

  initial begin
    rst_n        = 1'b0;
    instr        = 32'd0;
    mem_ready    = 1'b0;
    branch_taken = 1'b0;

    // Reset state
    step("reset_outs", E_NONE);
    chk("reset_alu", {27'd0, alu_control}, 32'd0);
    chk("reset_op2", {31'd0, op2_sel}, 32'd0);
    rst_n = 1'b1;

    // ALU, immediate and jump instructions
    run_wb("add",  32'h002081B3, 5'd0,  1'b1, 1'b0, E_WB_ALU);
    run_wb("sub",  32'h402081B3, 5'd1,  1'b1, 1'b0, E_WB_ALU);
    run_wb("srai", 32'h4030D093, 5'd7,  1'b1, 1'b1, E_WB_ALU);
    run_wb("xori", 32'h0050C093, 5'd2,  1'b1, 1'b1, E_WB_ALU);
    run_wb("jal",  32'h000000EF, 5'd18, 1'b0, 1'b0, E_WB_JAL);
    run_wb("jalr", 32'h000100E7, 5'd19, 1'b0, 1'b0, E_WB_JALR);

    // Branch taken then not taken: retire in cycle 3
    instr        = 32'h00208463;
    branch_taken = 1'b1;
    step("beqt_fetch", E_FETCH_RDY);
    step("beqt_decode", E_NONE);
    chk("beqt_alu", {27'd0, alu_control}, 32'd10);
    chk("beqt_op2", {31'd0, op2_sel}, 32'd0);
    step("beqt_execute", E_BR_T);
    branch_taken = 1'b0;
    step("beqn_fetch", E_FETCH_RDY);
    step("beqn_decode", E_NONE);
    step("beqn_execute", E_BR_N);

    // Load with memory stalled three cycles: retire in cycle 8
    instr = 32'h0000A283;
    step("lw_fetch", E_FETCH_RDY);
    mem_ready = 1'b0;
    step("lw_decode", E_NONE);
    chk("lw_alu", {27'd0, alu_control}, 32'd0);
    chk("lw_op2", {31'd0, op2_sel}, 32'd1);
    step("lw_execute", E_NONE);
    for (int i = 0; i < 3; i++)
      step("lw_mem_wait", E_MEM_LD);
    mem_ready = 1'b1;
    step("lw_mem_done", E_MEM_LD);
    mem_ready = 1'b0;
    step("lw_wb", E_WB_LD);

    // Store aborted by reset during MEM
    instr     = 32'h0020A023;
    mem_ready = 1'b1;
    step("sw_fetch", E_FETCH_RDY);
    mem_ready = 1'b0;
    step("sw_decode", E_NONE);
    step("sw_execute", E_NONE);
    step("sw_mem_wait", E_MEM_ST);
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    step("sw_rst_mid_mem", E_NONE);
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    rst_n     = 1'b1;

    // Fetch timeout: 16 waiting cycles then bus error trap
    step("to_fetch_c1", E_FETCH_WAIT);
    for (int i = 2; i <= 16; i++)
      step("to_fetch_wait", E_FETCH_WAIT);
    step("to_trap", E_TRAP_BUS);
    mem_ready = 1'b1;
    step("to_trap_hold", E_TRAP_BUS);
    step("to_trap_hold2", E_TRAP_BUS);

    // Ready on the timeout cycle wins; then illegal all-ones instruction
    do_reset();
    mem_ready = 1'b0;
    instr     = 32'hFFFFFFFF;
    for (int i = 1; i <= 15; i++)
      step("late_fetch_wait", E_FETCH_WAIT);
    mem_ready = 1'b1;
    step("late_fetch_c16", E_FETCH_RDY);
    mem_ready = 1'b0;
    step("late_decode", E_NONE);
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++)
      step("ill_trap_hold", E_TRAP_ILL);

    // Reset clears sticky flags
    do_reset();
    mem_ready = 1'b0;
    step("post_trap_reset", E_FETCH_WAIT);

    // Branch with reserved funct3 is illegal
    instr     = 32'h0020A463;
    mem_ready = 1'b1;
    step("bill_fetch", E_FETCH_RDY);
    step("bill_decode", E_NONE);
    step("bill_trap", E_TRAP_ILL);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
